// File: rtl/clk_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_multi
// Purpose  : CH independent programmable clock/waveform generators with
//            run-time period and high time, glitch-free stop and shadowed reload.
// Revision : 1.0  initial release
// ============================================================================
module clk_gen_multi #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         en,
    input  logic [CH-1:0]         load,
    input  logic [CH*CNT_W-1:0]   period,
    input  logic [CH*CNT_W-1:0]   high,
    output logic [CH-1:0]         clk_out,
    output logic [CH-1:0]         rise,
    output logic [CH-1:0]         running,
    output logic [CH-1:0]         pend
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_two = CNT_W'(2);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] r_p_act;
        logic [CNT_W-1:0] w_p_act_nxt;
        logic [CNT_W-1:0] r_h_act;
        logic [CNT_W-1:0] w_h_act_nxt;
        logic [CNT_W-1:0] r_p_sh;
        logic [CNT_W-1:0] w_p_sh_nxt;
        logic [CNT_W-1:0] r_h_sh;
        logic [CNT_W-1:0] w_h_sh_nxt;
        logic             r_pend;
        logic             w_pend_nxt;
        logic             r_clk_out;
        logic             w_clk_out_nxt;
        logic             r_rise;
        logic [CNT_W-1:0] w_ld_raw;
        logic [CNT_W-1:0] w_ld_p;
        logic [CNT_W-1:0] w_ld_h;

        assign w_ld_raw = period[k*CNT_W +: CNT_W];
        assign w_ld_h   = high[k*CNT_W +: CNT_W];
        // A period below 2 cannot produce both a high and a low phase.
        assign w_ld_p   = (w_ld_raw < c_two) ? c_two : w_ld_raw;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_p_act_nxt = r_p_act;
            w_h_act_nxt = r_h_act;
            w_p_sh_nxt  = r_p_sh;
            w_h_sh_nxt  = r_h_sh;
            w_pend_nxt  = r_pend;

            case (r_state)
                S_IDLE: begin
                    if (load[k]) begin
                        w_p_act_nxt = w_ld_p;
                        w_h_act_nxt = w_ld_h;
                    end
                    if (en[k]) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    if (r_cnt == r_p_act - c_one) begin
                        // Period boundary: settings may change and the channel may stop.
                        w_cnt_nxt  = '0;
                        w_pend_nxt = 1'b0;
                        if (r_pend) begin
                            w_p_act_nxt = r_p_sh;
                            w_h_act_nxt = r_h_sh;
                        end
                        if (load[k]) begin
                            w_p_act_nxt = w_ld_p;
                            w_h_act_nxt = w_ld_h;
                        end
                        if (!en[k]) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                        if (load[k]) begin
                            w_p_sh_nxt = w_ld_p;
                            w_h_sh_nxt = w_ld_h;
                            w_pend_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase

            w_clk_out_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt < w_h_act_nxt);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_p_act   <= c_two;
                r_h_act   <= c_one;
                r_p_sh    <= c_two;
                r_h_sh    <= c_one;
                r_pend    <= 1'b0;
                r_clk_out <= 1'b0;
                r_rise    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_p_act   <= w_p_act_nxt;
                r_h_act   <= w_h_act_nxt;
                r_p_sh    <= w_p_sh_nxt;
                r_h_sh    <= w_h_sh_nxt;
                r_pend    <= w_pend_nxt;
                r_clk_out <= w_clk_out_nxt;
                r_rise    <= w_clk_out_nxt & ~r_clk_out;
            end
        end

        assign clk_out[k] = r_clk_out;
        assign rise[k]    = r_rise;
        assign running[k] = (r_state == S_RUN);
        assign pend[k]    = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gen_multi
// Purpose  : Self-checking bench for clk_gen_multi: directed waveforms plus
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_gen_multi;
    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CH-1:0]        en = '0;
    logic [CH-1:0]        load = '0;
    logic [CH*CNT_W-1:0]  period = '0;
    logic [CH*CNT_W-1:0]  high = '0;
    logic [CH-1:0]        clk_out;
    logic [CH-1:0]        rise;
    logic [CH-1:0]        running;
    logic [CH-1:0]        pend;

    int total = 0;
    int bad   = 0;

    clk_gen_multi #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .period  (period),
        .high    (high),
        .clk_out (clk_out),
        .rise    (rise),
        .running (running),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    // Reference model: position within the period, active/pending settings.
    bit            m_run  [CH];
    int            m_pos  [CH];
    int            m_p    [CH];
    int            m_h    [CH];
    int            m_sp   [CH];
    int            m_sh   [CH];
    bit            m_pend [CH];
    logic [CH-1:0] e_out  = '0;
    logic [CH-1:0] e_rise = '0;
    logic [CH-1:0] e_run  = '0;
    logic [CH-1:0] e_pend = '0;

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            int lp;
            int lh;
            bit prev;
            lp   = int'(period[c*CNT_W +: CNT_W]);
            lh   = int'(high[c*CNT_W +: CNT_W]);
            if (lp < 2) lp = 2;
            prev = e_out[c];
            if (rst) begin
                m_run[c] = 0; m_pos[c] = 0; m_p[c] = 2; m_h[c] = 1;
                m_sp[c] = 2; m_sh[c] = 1; m_pend[c] = 0;
            end else if (!m_run[c]) begin
                if (load[c]) begin m_p[c] = lp; m_h[c] = lh; end
                if (en[c]) begin m_run[c] = 1; m_pos[c] = 0; end
            end else if (m_pos[c] == m_p[c] - 1) begin
                if (m_pend[c]) begin m_p[c] = m_sp[c]; m_h[c] = m_sh[c]; end
                if (load[c]) begin m_p[c] = lp; m_h[c] = lh; end
                m_pend[c] = 0;
                m_pos[c]  = 0;
                if (!en[c]) m_run[c] = 0;
            end else begin
                m_pos[c] = m_pos[c] + 1;
                if (load[c]) begin m_sp[c] = lp; m_sh[c] = lh; m_pend[c] = 1; end
            end
            e_out[c]  = m_run[c] && (m_pos[c] < m_h[c]);
            e_rise[c] = e_out[c] && !prev;
            e_run[c]  = m_run[c];
            e_pend[c] = m_pend[c];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int p, input int h);
        period[c*CNT_W +: CNT_W] = CNT_W'(p);
        high[c*CNT_W +: CNT_W]   = CNT_W'(h);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = '0;
        load = '0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        en     = '1;
        load   = '1;
        period = {CH{8'd5}};
        high   = {CH{8'd3}};
        tick();
        total++;
        if ({clk_out, rise, running, pend} !== '0) begin
            bad++;
            $display("FAIL reset_wins got=%b exp=0", {clk_out, rise, running, pend});
        end
        en   = '0;
        load = '0;
        rst  = 1'b0;
        tick();
        total++;
        if ({clk_out, rise, running, pend} !== '0) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=0", {clk_out, rise, running, pend});
        end
    endtask

    // Relies on reset defaults P=2, H=1 without any load.
    task automatic test_basic_divide();
        logic eo;
        do_reset();
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            eo = (i % 2 == 0);
            total++;
            if ({clk_out, rise[0], running[0]} !== {3'b000, eo, eo, 1'b1}) begin
                bad++;
                $display("FAIL basic_divide i=%0d got out=%b rise=%b run=%b exp out0=%b rise0=%b run0=1",
                         i, clk_out, rise[0], running[0], eo, eo);
            end
        end
        en = '0;
    endtask

    task automatic test_odd_period();
        logic [4:0] pa;
        logic [3:0] pb;
        logic [1:0] eo;
        logic [1:0] er;
        pa = 5'b11000;
        pb = 4'b1110;
        do_reset();
        set_ch(0, 5, 2);
        set_ch(1, 4, 3);
        load = 4'b0011;
        tick();
        load = '0;
        en   = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            eo = {pb[3 - (i % 4)], pa[4 - (i % 5)]};
            er = {1'(i % 4 == 0), 1'(i % 5 == 0)};
            total++;
            if ({clk_out[1:0], rise[1:0]} !== {eo, er}) begin
                bad++;
                $display("FAIL odd_period i=%0d got out=%b rise=%b exp out=%b rise=%b",
                         i, clk_out[1:0], rise[1:0], eo, er);
            end
        end
        en = '0;
    endtask

    task automatic test_mid_load();
        logic [10:0] eo;
        logic [10:0] ep;
        logic [8:0]  eo2;
        eo  = 11'b11000100100;
        ep  = 11'b00111000000;
        eo2 = 9'b110001001;
        do_reset();
        set_ch(0, 5, 2);
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        en[0]   = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            total++;
            if ({clk_out[0], pend[0]} !== {eo[10 - i], ep[10 - i]}) begin
                bad++;
                $display("FAIL mid_load i=%0d got out=%b pend=%b exp out=%b pend=%b",
                         i, clk_out[0], pend[0], eo[10 - i], ep[10 - i]);
            end
            if (i == 1) begin set_ch(0, 3, 1); load[0] = 1'b1; end
            if (i == 2) load[0] = 1'b0;
        end
        do_reset();
        set_ch(0, 5, 2);
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        en[0]   = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick();
            total++;
            if ({clk_out[0], pend[0]} !== {eo2[8 - i], 1'b0}) begin
                bad++;
                $display("FAIL wrap_load i=%0d got out=%b pend=%b exp out=%b pend=0",
                         i, clk_out[0], pend[0], eo2[8 - i]);
            end
            if (i == 4) begin set_ch(0, 3, 1); load[0] = 1'b1; end
            if (i == 5) load[0] = 1'b0;
        end
        en = '0;
    endtask

    task automatic test_graceful_stop();
        logic [7:0] eo;
        logic [7:0] er;
        eo = 8'b11100000;
        er = 8'b11111100;
        do_reset();
        set_ch(0, 6, 3);
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        en[0]   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({clk_out[0], running[0]} !== {eo[7 - i], er[7 - i]}) begin
                bad++;
                $display("FAIL graceful_stop i=%0d got out=%b run=%b exp out=%b run=%b",
                         i, clk_out[0], running[0], eo[7 - i], er[7 - i]);
            end
            if (i == 1) en[0] = 1'b0;
        end
        en[0] = 1'b1;
        tick();
        total++;
        if ({clk_out[0], rise[0], running[0]} !== 3'b111) begin
            bad++;
            $display("FAIL restart got out/rise/run=%b%b%b exp=111", clk_out[0], rise[0], running[0]);
        end
        en = '0;
    endtask

    task automatic test_boundaries();
        logic eo;
        do_reset();
        set_ch(0, 0, 1);
        set_ch(1, 3, 0);
        set_ch(2, 4, 9);
        set_ch(3, 1, 1);
        load = '1;
        tick();
        load = '0;
        en   = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            eo = (i % 2 == 0);
            total++;
            if ({clk_out, rise, running} !== {eo, 1'b1, 1'b0, eo, eo, 1'(i == 0), 1'b0, eo, 4'b1111}) begin
                bad++;
                $display("FAIL boundaries i=%0d got out=%b rise=%b run=%b exp out=%b rise=%b run=1111",
                         i, clk_out, rise, running, {eo, 1'b1, 1'b0, eo}, {eo, 1'(i == 0), 1'b0, eo});
            end
        end
        en = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < CH; c++) set_ch(c, int'($urandom_range(3, 9)), int'($urandom_range(1, 4)));
        load = '1;
        tick();
        load = '0;
        en   = '1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 2) begin
                for (int c = 0; c < CH; c++) set_ch(c, 7, 2);
                load = '1;
            end else begin
                load = '0;
            end
        end
        load = '0;
        rst  = 1'b1;
        tick();
        total++;
        if ({clk_out, rise, running, pend} !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=0", {clk_out, rise, running, pend});
        end
        rst = 1'b0;
        tick();
        total++;
        if ({clk_out, rise, running, pend} !== {4'hF, 4'hF, 4'hF, 4'h0}) begin
            bad++;
            $display("FAIL reset_restart got=%b exp=%b", {clk_out, rise, running, pend}, 16'hFFF0);
        end
        tick();
        total++;
        if ({clk_out, rise, running, pend} !== {4'h0, 4'h0, 4'hF, 4'h0}) begin
            bad++;
            $display("FAIL reset_revert got=%b exp=%b", {clk_out, rise, running, pend}, 16'h00F0);
        end
        en = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) en[c] = ~en[c];
                load[c] = ($urandom_range(0, 5) == 0);
                set_ch(c, int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
            total++;
            if ({clk_out, rise, running, pend} !== {e_out, e_rise, e_run, e_pend}) begin
                bad++;
                $display("FAIL random i=%0d got out=%b rise=%b run=%b pend=%b exp out=%b rise=%b run=%b pend=%b",
                         i, clk_out, rise, running, pend, e_out, e_rise, e_run, e_pend);
            end
        end
        rst  = 1'b0;
        en   = '0;
        load = '0;
    endtask

    initial begin
        test_reset();
        test_basic_divide();
        test_odd_period();
        test_mid_load();
        test_graceful_stop();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
